prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 170 +++++++++++++++++
 tb/tb_prefetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM feeding a circular FIFO of {instruction, pc}.
// Latency: redirect -> mem_req next cycle; a word acked in cycle N is at the head in cycle N+1.
// Backpressure: fetching pauses when the queue would be full; deq is ignored when empty; redirect flushes.
module prefetch_queue #(
  parameter int          DEPTH    = 4,        // power of two, 2..8
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        deq,
  output logic        inst_valid,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pcNext,
  output logic [3:0]  count,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] L_DEPTH = 4'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // nothing outstanding
    S_REQ  = 2'd1,   // request outstanding, response wanted
    S_DROP = 2'd2    // request outstanding, response discarded after a flush
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_mem_req;
  logic [15:0]   r_mem_addr, w_mem_addr_next;
  logic [15:0]   r_fetch_pc, w_fetch_pc_next;
  logic [PW-1:0] r_head, r_tail, w_head_next;
  logic [3:0]    r_count, w_count_next;
  logic [15:0]   r_q_inst [DEPTH];
  logic [15:0]   r_q_pc   [DEPTH];
  logic [15:0]   r_inst_out, r_inst_pc, r_inst_pcnext;

  logic          w_redirect_pc_even;
  logic [15:0]   w_redirect_pc;
  logic          w_wr, w_rd, w_bypass;
  logic [15:0]   w_head_inst, w_head_pc;

  assign w_redirect_pc_even = 1'b1;
  assign w_redirect_pc = redirect_pc & 16'hFFFE;

  // Only a wanted response writes; a flush in the same cycle wins over the write.
  assign w_wr = (r_state == S_REQ) && mem_ack && !redirect;
  // Pops are only honoured with a valid head and are discarded by a flush.
  assign w_rd = deq && (r_count != 4'd0) && !redirect;

  assign w_count_next = redirect ? 4'd0 : (r_count + {3'b000, w_wr} - {3'b000, w_rd});
  assign w_head_next  = redirect ? '0 : (w_rd ? r_head + PW'(1) : r_head);

  // The entry written this cycle becomes the head when the queue is otherwise empty after the pop.
  assign w_bypass    = w_wr && (r_tail == w_head_next);
  assign w_head_inst = w_bypass ? mem_data   : r_q_inst[w_head_next];
  assign w_head_pc   = w_bypass ? r_mem_addr : r_q_pc[w_head_next];

  // Fetch FSM next-state, next request address and next fetch pointer.
  always_comb begin
    w_state_next    = r_state;
    w_mem_addr_next = r_mem_addr;
    w_fetch_pc_next = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_next = w_redirect_pc;
      // An ack this cycle retires the old request, so the restart can issue at once.
      if (r_state == S_IDLE || mem_ack) begin
        w_state_next    = S_REQ;
        w_mem_addr_next = w_redirect_pc;
      end else begin
        w_state_next    = S_DROP;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count_next < L_DEPTH) begin
            w_state_next    = S_REQ;
            w_mem_addr_next = r_fetch_pc;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            w_fetch_pc_next = r_mem_addr + 16'd2;
            if (w_count_next < L_DEPTH) begin
              w_mem_addr_next = r_mem_addr + 16'd2;
            end else begin
              w_state_next    = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            w_state_next    = S_REQ;
            w_mem_addr_next = r_fetch_pc;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Fetch FSM state, registered request outputs and fetch pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 16'h0000;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_mem_req  <= (w_state_next != S_IDLE);
      r_mem_addr <= w_mem_addr_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 4'd0;
    end else begin
      r_head  <= w_head_next;
      r_count <= w_count_next;
      if (redirect) begin
        r_tail <= '0;
      end else if (w_wr) begin
        r_tail <= r_tail + PW'(1);
      end
    end
  end

  // Queue storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_q_inst[r_tail] <= mem_data;
      r_q_pc[r_tail]   <= r_mem_addr;
    end
  end

  // Registered head view; holds its last value while the queue is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_out    <= 16'h0000;
      r_inst_pc     <= 16'h0000;
      r_inst_pcnext <= 16'h0000;
    end else if (w_count_next != 4'd0) begin
      r_inst_out    <= w_head_inst;
      r_inst_pc     <= w_head_pc;
      r_inst_pcnext <= w_head_pc + 16'd2;
    end
  end

  assign inst_valid  = (r_count != 4'd0) && w_redirect_pc_even;
  assign inst_out    = r_inst_out;
  assign inst_pc     = r_inst_pc;
  assign inst_pcNext = r_inst_pcnext;
  assign count       = r_count;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fetch, streaming, flush, wrap and async reset scenarios.
// Memory responds with word = addr ^ 16'hC3C3 so every captured word identifies its address.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        deq;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic [15:0] inst_pcNext;
  logic [3:0]  count;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  int n_vec = 0;
  int n_err = 0;

  prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_pcNext(inst_pcNext),
    .count(count), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] wfn(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  // Advance one rising edge, then present the word for the current request address.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_data = wfn(mem_addr);
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; deq = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
    #3;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", inst_valid); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", mem_req); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_vec++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_addr got %h want 0000", mem_addr); end
    n_vec++; if (inst_out !== 16'h0) begin n_err++; $display("FAIL rst_inst got %h want 0000", inst_out); end
    n_vec++; if (inst_pc !== 16'h0) begin n_err++; $display("FAIL rst_pc got %h want 0000", inst_pc); end
    n_vec++; if (inst_pcNext !== 16'h0) begin n_err++; $display("FAIL rst_pcnext got %h want 0000", inst_pcNext); end
    tick();
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_clk_req got %b want 0", mem_req); end
  endtask

  task automatic test_sequential();
    rst = 1'b1;
    tick();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL seq_first_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL seq_first_addr got %h want 0000", mem_addr); end
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (count !== 4'(i + 1)) begin n_err++; $display("FAIL seq_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_vec++; if (inst_pc !== 16'h0000) begin n_err++; $display("FAIL seq_head_pc[%0d] got %h want 0000", i, inst_pc); end
    end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL seq_full_req got %b want 0", mem_req); end
    n_vec++; if (inst_out !== wfn(16'h0)) begin n_err++; $display("FAIL seq_inst got %h want %h", inst_out, wfn(16'h0)); end
    n_vec++; if (inst_pcNext !== 16'h0002) begin n_err++; $display("FAIL seq_pcnext got %h want 0002", inst_pcNext); end
    tick();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL seq_full_hold got %0d want 4", count); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL seq_full_hold_req got %b want 0", mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_deq_partial();
    deq = 1'b1;
    tick();
    deq = 1'b0;
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL deq_count got %0d want 3", count); end
    n_vec++; if (inst_pc !== 16'h0002) begin n_err++; $display("FAIL deq_pc got %h want 0002", inst_pc); end
    n_vec++; if (inst_out !== wfn(16'h2)) begin n_err++; $display("FAIL deq_inst got %h want %h", inst_out, wfn(16'h2)); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL deq_refill_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 16'h0008) begin n_err++; $display("FAIL deq_refill_addr got %h want 0008", mem_addr); end
  endtask

  task automatic test_streaming();
    // Odd restart address: bit 0 must be dropped.
    redirect = 1'b1; redirect_pc = 16'h0001; mem_ack = 1'b1; deq = 1'b1;
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL stream_flush_count got %0d want 0", count); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_flush_valid got %b want 0", inst_valid); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL stream_restart_addr got %h want 0000", mem_addr); end
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, inst_valid); end
      n_vec++; if (inst_pc !== 16'(2 * i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_pc, 16'(2 * i)); end
      n_vec++; if (inst_out !== wfn(16'(2 * i))) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst_out, wfn(16'(2 * i))); end
      n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
    end
    deq = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_flush_in_flight();
    redirect = 1'b1; redirect_pc = 16'h0008; mem_ack = 1'b1;
    tick();
    n_vec++; if (mem_addr !== 16'h0008) begin n_err++; $display("FAIL flush_setup_addr got %h want 0008", mem_addr); end
    redirect_pc = 16'h0040; mem_ack = 1'b0;
    tick();
    redirect = 1'b0;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL flush_req_kept got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 16'h0008) begin n_err++; $display("FAIL flush_addr_stable got %h want 0008", mem_addr); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (mem_addr !== 16'h0008) begin n_err++; $display("FAIL flush_wait_addr[%0d] got %h want 0008", i, mem_addr); end
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_wait_count[%0d] got %0d want 0", i, count); end
    end
    mem_ack = 1'b1;
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_drop_count got %0d want 0", count); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_valid got %b want 0", inst_valid); end
    n_vec++; if (mem_addr !== 16'h0040) begin n_err++; $display("FAIL flush_new_addr got %h want 0040", mem_addr); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL flush_new_req got %b want 1", mem_req); end
    tick();
    n_vec++; if (inst_pc !== 16'h0040) begin n_err++; $display("FAIL flush_first_pc got %h want 0040", inst_pc); end
    n_vec++; if (inst_out !== wfn(16'h0040)) begin n_err++; $display("FAIL flush_first_inst got %h want %h", inst_out, wfn(16'h0040)); end
    mem_ack = 1'b0;
  endtask

  task automatic test_redirect_ack_deq();
    mem_ack = 1'b1;
    tick();
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL rad_setup_count got %0d want 2", count); end
    redirect = 1'b1; redirect_pc = 16'h0100; deq = 1'b1;
    tick();
    redirect = 1'b0; deq = 1'b0; mem_ack = 1'b0;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rad_count got %0d want 0", count); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rad_valid got %b want 0", inst_valid); end
    n_vec++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL rad_addr got %h want 0100", mem_addr); end
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rad_no_ghost got %0d want 0", count); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_vec++; if (inst_pc !== 16'h0100) begin n_err++; $display("FAIL rad_first_pc got %h want 0100", inst_pc); end
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL rad_first_count got %0d want 1", count); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFC; mem_ack = 1'b1;
    tick();
    redirect = 1'b0; mem_ack = 1'b0; deq = 1'b1;
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_deq_count got %0d want 0", count); end
    n_vec++; if (mem_addr !== 16'hFFFC) begin n_err++; $display("FAIL empty_deq_addr got %h want fffc", mem_addr); end
    mem_ack = 1'b1;
    tick();
    n_vec++; if (inst_pc !== 16'hFFFC) begin n_err++; $display("FAIL wrap_pc0 got %h want fffc", inst_pc); end
    n_vec++; if (inst_pcNext !== 16'hFFFE) begin n_err++; $display("FAIL wrap_next0 got %h want fffe", inst_pcNext); end
    tick();
    n_vec++; if (inst_pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_pc1 got %h want fffe", inst_pc); end
    n_vec++; if (inst_pcNext !== 16'h0000) begin n_err++; $display("FAIL wrap_next1 got %h want 0000", inst_pcNext); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got %h want 0000", mem_addr); end
    tick();
    n_vec++; if (inst_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc2 got %h want 0000", inst_pc); end
    n_vec++; if (inst_out !== wfn(16'h0000)) begin n_err++; $display("FAIL wrap_inst2 got %h want %h", inst_out, wfn(16'h0)); end
    mem_ack = 1'b0; deq = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", inst_valid); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL arst_req got %b want 0", mem_req); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
    n_vec++; if (inst_pc !== 16'h0000) begin n_err++; $display("FAIL arst_pc got %h want 0000", inst_pc); end
    // A stray ack right after release lands in IDLE and must be ignored.
    mem_ack = 1'b1;
    #2;
    rst = 1'b1;
    tick();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL arst_refetch_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL arst_refetch_addr got %h want 0000", mem_addr); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL arst_stray_ack got %0d want 0", count); end
    tick();
    mem_ack = 1'b0;
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL arst_first_count got %0d want 1", count); end
    n_vec++; if (inst_out !== wfn(16'h0000)) begin n_err++; $display("FAIL arst_first_inst got %h want %h", inst_out, wfn(16'h0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_deq_partial();
    test_streaming();
    test_flush_in_flight();
    test_redirect_ack_deq();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
